// File: rtl/alien_pkg.sv
// Shared definitions for the alien formation block: grid geometry, FSM state
// encoding and the row/column to alive-bit index mapping.
// Ports: none (package).
package alien_pkg;

  localparam int ROWS          = 4;
  localparam int COLS          = 9;
  localparam int NUM_ALIENS    = ROWS * COLS;
  localparam int ALIENS_WIDTH  = 20;
  localparam int ALIENS_HEIGHT = 10;

  typedef enum logic [2:0] {
    S_RUN,
    S_DECIDE,
    S_DESCEND,
    S_CHECK,
    S_HALT
  } state_t;

  // Alive-mask bit for alien (row, col): 9*row + col.
  function automatic logic [5:0] alien_idx(input int row, input int col);
    return 6'(COLS * row + col);
  endfunction

endpackage

// File: rtl/alien_hit_locator.sv
// Combinational point-in-box search over the 36 alien boxes of the formation.
// Ports: i_valid/i_x_pt/i_y_pt = missile tip, i_x_origin/i_y_origin = formation
//        origin, i_alive = alive mask; o_hit/o_hit_index = matching live alien.
module alien_hit_locator #(
  parameter int ALIENS_WIDTH  = 20,
  parameter int ALIENS_HEIGHT = 10
) (
  input  logic        i_valid,
  input  logic [9:0]  i_x_origin,
  input  logic [9:0]  i_y_origin,
  input  logic [9:0]  i_x_pt,
  input  logic [9:0]  i_y_pt,
  input  logic [35:0] i_alive,
  output logic        o_hit,
  output logic [5:0]  o_hit_index
);

  import alien_pkg::*;

  logic [10:0] w_x_pt;
  logic [10:0] w_y_pt;
  logic [10:0] w_left;
  logic [10:0] w_top;

  assign w_x_pt = {1'b0, i_x_pt};
  assign w_y_pt = {1'b0, i_y_pt};

  // Boxes are disjoint, so at most one iteration can match; strict bounds
  // mean a point sitting exactly on a box edge never matches.
  always_comb begin
    o_hit       = 1'b0;
    o_hit_index = '0;
    w_left      = '0;
    w_top       = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        w_left = {1'b0, i_x_origin} + 11'(2 * ALIENS_WIDTH * c);
        w_top  = {1'b0, i_y_origin} + 11'(2 * ALIENS_HEIGHT * r);
        if (i_valid && i_alive[alien_idx(r, c)] &&
            (w_left < w_x_pt) && (w_x_pt < w_left + 11'(ALIENS_WIDTH)) &&
            (w_top  < w_y_pt) && (w_y_pt < w_top  + 11'(ALIENS_HEIGHT))) begin
          o_hit       = 1'b1;
          o_hit_index = alien_idx(r, c);
        end
      end
    end
  end

endmodule

// File: rtl/alien_formation_ctrl.sv
// Owns the 4x9 alien formation: origin, alive mask, march/descend/reverse on
// frame ticks, missile kills and the sticky invasion flag.
// Ports: clk/rst (sync, active-high), frameTick, missileValid/xMissile/yMissile
//        in; xAlien/yAlien/alive/missileHit/hitIndex/allDead/invaded out.
// Optional macro ALIEN_SPEEDUP_EN: march period shortens by one frame per
// four kills (floor 1); without it the period is fixed at STEP_PERIOD.
module alien_formation_ctrl #(
  parameter int X0            = 40,
  parameter int Y0            = 40,
  parameter int ALIENS_WIDTH  = alien_pkg::ALIENS_WIDTH,
  parameter int ALIENS_HEIGHT = alien_pkg::ALIENS_HEIGHT,
  parameter int STEP_X        = 4,
  parameter int STEP_Y        = 10,
  parameter int STEP_PERIOD   = 30,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 639,
  parameter int Y_LIMIT       = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frameTick,
  input  logic        missileValid,
  input  logic [9:0]  xMissile,
  input  logic [9:0]  yMissile,
  output logic [9:0]  xAlien,
  output logic [9:0]  yAlien,
  output logic [35:0] alive,
  output logic        missileHit,
  output logic [5:0]  hitIndex,
  output logic        allDead,
  output logic        invaded
);

  import alien_pkg::*;

  localparam int CW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;

  state_t       r_state, w_state_nxt;
  logic [9:0]   r_x, w_x_nxt;
  logic [9:0]   r_y, w_y_nxt;
  logic [35:0]  r_alive, w_alive_nxt;
  logic         r_dirLeft, w_dirLeft_nxt;
  logic [CW-1:0] r_tickCnt, w_tickCnt_nxt;
  logic         r_hit;
  logic [5:0]   r_hitIdx;
  logic         r_invaded, w_invaded_nxt;

  logic         w_hit;
  logic [5:0]   w_hitIdx;
  logic         w_allDead;
  logic [CW-1:0] w_periodM1;

  logic [COLS-1:0] w_colAny;
  logic [ROWS-1:0] w_rowAny;
  logic [3:0]      w_leftCol, w_rightCol;
  logic [1:0]      w_botRow;
  logic [10:0]     w_x11, w_y11, w_rightEdge, w_leftEdge, w_botEdge;

  assign w_allDead = (r_alive == '0);

  // ---------------------------------------------------------------------
  // Effective march period (minus one, to compare against the tick count)
  // ---------------------------------------------------------------------
`ifdef ALIEN_SPEEDUP_EN
  int w_liveCnt;
  int w_period;
  always_comb begin
    w_liveCnt = 0;
    for (int i = 0; i < NUM_ALIENS; i++) begin
      w_liveCnt = w_liveCnt + (r_alive[i] ? 1 : 0);
    end
    w_period = STEP_PERIOD - ((NUM_ALIENS - w_liveCnt) / 4);
    if (w_period < 1) begin
      w_period = 1;
    end
    w_periodM1 = CW'(w_period - 1);
  end
`else
  assign w_periodM1 = CW'(STEP_PERIOD - 1);
`endif

  // ---------------------------------------------------------------------
  // Formation extents from the alive mask
  // ---------------------------------------------------------------------
  always_comb begin
    w_colAny = '0;
    w_rowAny = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r_alive[alien_idx(r, c)]) begin
          w_colAny[c] = 1'b1;
          w_rowAny[r] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_leftCol  = '0;
    w_rightCol = '0;
    w_botRow   = '0;
    // Descending scan: last write is the lowest occupied column.
    for (int c = COLS - 1; c >= 0; c--) begin
      if (w_colAny[c]) w_leftCol = 4'(c);
    end
    for (int c = 0; c < COLS; c++) begin
      if (w_colAny[c]) w_rightCol = 4'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (w_rowAny[r]) w_botRow = 2'(r);
    end
  end

  // 11-bit sums so screen-edge tests never wrap.
  assign w_x11       = {1'b0, r_x};
  assign w_y11       = {1'b0, r_y};
  assign w_rightEdge = w_x11 + 11'(2 * ALIENS_WIDTH * int'(w_rightCol))
                     + 11'(ALIENS_WIDTH + STEP_X);
  assign w_leftEdge  = w_x11 + 11'(2 * ALIENS_WIDTH * int'(w_leftCol));
  assign w_botEdge   = w_y11 + 11'(2 * ALIENS_HEIGHT * int'(w_botRow))
                     + 11'(ALIENS_HEIGHT);

  // ---------------------------------------------------------------------
  // Missile hit search against the current registered origin
  // ---------------------------------------------------------------------
  alien_hit_locator #(
    .ALIENS_WIDTH  (ALIENS_WIDTH),
    .ALIENS_HEIGHT (ALIENS_HEIGHT)
  ) u_locator (
    .i_valid     (missileValid),
    .i_x_origin  (r_x),
    .i_y_origin  (r_y),
    .i_x_pt      (xMissile),
    .i_y_pt      (yMissile),
    .i_alive     (r_alive),
    .o_hit       (w_hit),
    .o_hit_index (w_hitIdx)
  );

  // Kills apply in every state, independently of the march FSM.
  always_comb begin
    w_alive_nxt = r_alive;
    if (w_hit) begin
      w_alive_nxt[w_hitIdx] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // March FSM: next state and datapath updates
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_dirLeft_nxt = r_dirLeft;
    w_tickCnt_nxt = r_tickCnt;
    w_invaded_nxt = r_invaded;
    case (r_state)
      S_RUN: begin
        // With nothing alive the count freezes and no step is scheduled.
        if (frameTick && !w_allDead) begin
          if (r_tickCnt >= w_periodM1) begin
            w_tickCnt_nxt = '0;
            w_state_nxt   = S_DECIDE;
          end else begin
            w_tickCnt_nxt = r_tickCnt + 1'b1;
          end
        end
      end
      S_DECIDE: begin
        if (w_allDead) begin
          w_state_nxt = S_RUN;
        end else if (!r_dirLeft) begin
          if (w_rightEdge > 11'(X_MAX)) begin
            w_state_nxt = S_DESCEND;
          end else begin
            w_x_nxt     = r_x + 10'(STEP_X);
            w_state_nxt = S_RUN;
          end
        end else begin
          if (w_leftEdge < 11'(X_MIN + STEP_X)) begin
            w_state_nxt = S_DESCEND;
          end else begin
            w_x_nxt     = r_x - 10'(STEP_X);
            w_state_nxt = S_RUN;
          end
        end
      end
      S_DESCEND: begin
        if (w_allDead) begin
          w_state_nxt = S_RUN;
        end else begin
          w_y_nxt       = r_y + 10'(STEP_Y);
          w_dirLeft_nxt = ~r_dirLeft;
          w_state_nxt   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!w_allDead && (w_botEdge >= 11'(Y_LIMIT))) begin
          w_invaded_nxt = 1'b1;
          w_state_nxt   = S_HALT;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_x       <= 10'(X0);
      r_y       <= 10'(Y0);
      r_alive   <= '1;
      r_dirLeft <= 1'b0;
      r_tickCnt <= '0;
      r_hit     <= 1'b0;
      r_hitIdx  <= '0;
      r_invaded <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_alive   <= w_alive_nxt;
      r_dirLeft <= w_dirLeft_nxt;
      r_tickCnt <= w_tickCnt_nxt;
      r_hit     <= w_hit;
      r_hitIdx  <= w_hitIdx;
      r_invaded <= w_invaded_nxt;
    end
  end

  assign xAlien     = r_x;
  assign yAlien     = r_y;
  assign alive      = r_alive;
  assign missileHit = r_hit;
  assign hitIndex   = r_hitIdx;
  assign allDead    = w_allDead;
  assign invaded    = r_invaded;

endmodule

// File: tb/tb_alien_formation_ctrl.sv
module tb_alien_formation_ctrl;

  localparam int W    = 20;
  localparam int H    = 10;
  localparam int P    = 30;
  localparam int SX   = 4;
  localparam int SY   = 10;
  localparam int XMIN = 0;
  localparam int XMAX = 639;
  localparam int YL   = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst, tick, mv;
  logic [9:0]  xm, ym;
  logic [9:0]  xa, ya;
  logic [35:0] al;
  logic        hit, dead, inv;
  logic [5:0]  hidx;

  // Fast-march instance (one frame per step) for long multi-descent runs
  logic        f_rst, f_tick, f_mv;
  logic [9:0]  f_xm, f_ym;
  logic [9:0]  f_xa, f_ya;
  logic [35:0] f_al;
  logic        f_hit, f_dead, f_inv;
  logic [5:0]  f_hidx;

  alien_formation_ctrl u_dut (
    .clk(clk), .rst(rst), .frameTick(tick), .missileValid(mv),
    .xMissile(xm), .yMissile(ym), .xAlien(xa), .yAlien(ya), .alive(al),
    .missileHit(hit), .hitIndex(hidx), .allDead(dead), .invaded(inv)
  );

  alien_formation_ctrl #(.STEP_PERIOD(1)) u_fast (
    .clk(clk), .rst(f_rst), .frameTick(f_tick), .missileValid(f_mv),
    .xMissile(f_xm), .yMissile(f_ym), .xAlien(f_xa), .yAlien(f_ya), .alive(f_al),
    .missileHit(f_hit), .hitIndex(f_hidx), .allDead(f_dead), .invaded(f_inv)
  );

  int errs = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_period(input int kills);
    int p;
    p = P;
`ifdef ALIEN_SPEEDUP_EN
    p = P - kills / 4;
    if (p < 1) p = 1;
`endif
    return p;
  endfunction

  task automatic dut_reset();
    rst = 1'b1; tick = 1'b0; mv = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic f_reset();
    f_rst = 1'b1; f_tick = 1'b0; f_mv = 1'b0;
    cyc();
    f_rst = 1'b0;
  endtask

  // n frame ticks back to back, then one idle cycle for the decision edge
  task automatic do_step(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
    cyc();
  endtask

  // ---------------------------------------------------------------------
  // Reference model (default instance)
  // ---------------------------------------------------------------------
  int          m_x, m_y, m_cnt, m_phase, m_idx;  // phase: 0 run,1 decide,2 descend,3 check,4 halt
  logic [35:0] m_alive;
  bit          m_left, m_hit, m_inv;

  task automatic model_init();
    m_x = 40; m_y = 40; m_cnt = 0; m_phase = 0; m_idx = 0;
    m_alive = '1; m_left = 0; m_hit = 0; m_inv = 0;
  endtask

  task automatic model_cycle(input bit tk, input bit v, input int px, input int py);
    int dx, dy, c, r, lc, rc, br, per, nx, ny, ncnt, nph, hi;
    bit nleft, ninv, h;
    logic [35:0] na;
    h = 0; hi = 0;
    dx = px - m_x; dy = py - m_y;
    if (v && dx > 0 && dy > 0) begin
      c = dx / (2 * W); r = dy / (2 * H);
      if (c < 9 && r < 4 && (dx % (2 * W)) > 0 && (dx % (2 * W)) < W &&
          (dy % (2 * H)) > 0 && (dy % (2 * H)) < H && m_alive[9 * r + c]) begin
        h = 1; hi = 9 * r + c;
      end
    end
    lc = 99; rc = -1; br = -1;
    for (int i = 0; i < 36; i++) begin
      if (m_alive[i]) begin
        if (i % 9 < lc) lc = i % 9;
        if (i % 9 > rc) rc = i % 9;
        if (i / 9 > br) br = i / 9;
      end
    end
    per = eff_period(36 - $countones(m_alive));
    nx = m_x; ny = m_y; ncnt = m_cnt; nph = m_phase; nleft = m_left; ninv = m_inv;
    case (m_phase)
      0: if (tk && m_alive != 0) begin
           if (m_cnt >= per - 1) begin ncnt = 0; nph = 1; end
           else ncnt = m_cnt + 1;
         end
      1: if (m_alive == 0) nph = 0;
         else if (!m_left) begin
           if (m_x + 2 * W * rc + W + SX > XMAX) nph = 2;
           else begin nx = m_x + SX; nph = 0; end
         end else begin
           if (m_x + 2 * W * lc < XMIN + SX) nph = 2;
           else begin nx = m_x - SX; nph = 0; end
         end
      2: if (m_alive == 0) nph = 0;
         else begin ny = m_y + SY; nleft = !m_left; nph = 3; end
      3: if (m_alive != 0 && m_y + 2 * H * br + H >= YL) begin ninv = 1; nph = 4; end
         else nph = 0;
      default: ;
    endcase
    na = m_alive;
    if (h) na[hi] = 1'b0;
    m_x = nx; m_y = ny; m_cnt = ncnt; m_phase = nph; m_left = nleft; m_inv = ninv;
    m_alive = na; m_hit = h; m_idx = hi;
  endtask

  typedef struct {
    logic v;
    int   x;
    int   y;
    logic eh;
    int   ei;
  } vec_t;

  vec_t        vt[13];
  logic [35:0] ea;

  initial begin
    rst = 1'b1; tick = 1'b0; mv = 1'b0; xm = '0; ym = '0;
    f_rst = 1'b1; f_tick = 1'b0; f_mv = 1'b0; f_xm = '0; f_ym = '0;
    cyc(); cyc();
    rst = 1'b0; f_rst = 1'b0;

    // Reset state
    check("rst_x", 64'(xa), 64'd40);
    check("rst_y", 64'(ya), 64'd40);
    check("rst_alive", 64'(al), 64'hFFFFFFFFF);
    check("rst_hit", 64'(hit), 64'd0);
    check("rst_idx", 64'(hidx), 64'd0);
    check("rst_inv", 64'(inv), 64'd0);
    check("rst_dead", 64'(dead), 64'd0);

    // Missile hit vectors against origin (40,40)
    vt[0]  = '{1'b1,  50,  45, 1'b1,  0};
    vt[1]  = '{1'b1,  50,  45, 1'b0,  0};
    vt[2]  = '{1'b1,  60,  45, 1'b0,  0};
    vt[3]  = '{1'b1,  70,  45, 1'b0,  0};
    vt[4]  = '{1'b1,  40,  45, 1'b0,  0};
    vt[5]  = '{1'b1,  90,  65, 1'b1, 10};
    vt[6]  = '{1'b1, 370, 105, 1'b1, 35};
    vt[7]  = '{1'b1, 335, 100, 1'b0,  0};
    vt[8]  = '{1'b0, 335, 105, 1'b0,  0};
    vt[9]  = '{1'b1, 335, 105, 1'b1, 34};
    vt[10] = '{1'b1, 139,  89, 1'b1, 20};
    vt[11] = '{1'b1, 121,  81, 1'b0,  0};
    vt[12] = '{1'b1,  81,  41, 1'b1,  1};
    ea = '1;
    for (int i = 0; i < 13; i++) begin
      mv = vt[i].v; xm = 10'(vt[i].x); ym = 10'(vt[i].y);
      cyc();
      if (vt[i].eh) ea[vt[i].ei] = 1'b0;
      check("vec_hit", 64'(hit), 64'(vt[i].eh));
      if (vt[i].eh) check("vec_idx", 64'(hidx), 64'(vt[i].ei));
      check("vec_alive", 64'(al), 64'(ea));
    end
    mv = 1'b0;
    cyc();
    check("hit_pulse_drop", 64'(hit), 64'd0);

    // March right, descend at x=296, then move left
    dut_reset();
    do_step(P);
    check("march_first", 64'(xa), 64'd44);
    repeat (63) do_step(P);
    check("march_64_x", 64'(xa), 64'd296);
    check("march_64_y", 64'(ya), 64'd40);
    do_step(P); cyc(); cyc();
    check("descend_y", 64'(ya), 64'd50);
    check("descend_x", 64'(xa), 64'd296);
    do_step(P);
    check("reverse_x", 64'(xa), 64'd292);

    // Column 8 dead: right edge moves in, descent at x=336
    dut_reset();
    for (int r = 0; r < 4; r++) begin
      mv = 1'b1; xm = 10'd370; ym = 10'(45 + 20 * r);
      cyc();
      check("col8_hit", 64'(hit), 64'd1);
      check("col8_idx", 64'(hidx), 64'(9 * r + 8));
    end
    mv = 1'b0;
    repeat (74) do_step(eff_period(4));
    check("col8_x", 64'(xa), 64'd336);
    check("col8_y", 64'(ya), 64'd40);
    do_step(eff_period(4)); cyc(); cyc();
    check("col8_descend_y", 64'(ya), 64'd50);
    check("col8_descend_x", 64'(xa), 64'd336);

    // Reset in the middle of counting restores everything, including the count
    tick = 1'b1;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_x", 64'(xa), 64'd40);
    check("midrst_y", 64'(ya), 64'd40);
    check("midrst_alive", 64'(al), 64'hFFFFFFFFF);
    repeat (P - 1) cyc();
    tick = 1'b0;
    cyc(); cyc();
    check("midrst_cnt_hold", 64'(xa), 64'd40);
    do_step(1);
    check("midrst_cnt_step", 64'(xa), 64'd44);

    // Randomized run against the reference model
    dut_reset();
    model_init();
    for (int n = 0; n < 6000; n++) begin
      int r, c, px, py;
      bit tk, v;
      tk = ($urandom_range(0, 99) < 80);
      v  = ($urandom_range(0, 99) < 1);
      r  = $urandom_range(0, 3);
      c  = $urandom_range(1, 8);
      px = m_x + 2 * W * c + $urandom_range(0, W + 4) - 2;
      py = m_y + 2 * H * r + $urandom_range(0, H + 4) - 2;
      tick = tk; mv = v; xm = 10'(px); ym = 10'(py);
      model_cycle(tk, v, px, py);
      cyc();
      check("rnd_state", {5'd0, xa, ya, al, hit, inv, dead},
            {5'd0, 10'(m_x), 10'(m_y), m_alive, m_hit, m_inv, (m_alive == '0)});
      if (m_hit) check("rnd_idx", 64'(hidx), 64'(m_idx));
    end
    tick = 1'b0; mv = 1'b0;

    // Hit and step on the same edge (fast instance)
    f_reset();
    f_tick = 1'b1;
    cyc();
    f_tick = 1'b0; f_mv = 1'b1; f_xm = 10'd50; f_ym = 10'd45;
    cyc();
    f_mv = 1'b0;
    check("same_cyc_x", 64'(f_xa), 64'd44);
    check("same_cyc_hit", 64'(f_hit), 64'd1);
    check("same_cyc_alive", 64'(f_al), 64'hFFFFFFFFE);

    // Repeated descents until the bottom row reaches the invasion line
    f_reset();
    f_tick = 1'b1;
    for (int i = 0; i < 20000 && f_inv !== 1'b1; i++) cyc();
    check("inv_flag", 64'(f_inv), 64'd1);
    check("inv_y", 64'(f_ya), 64'd330);
    check("inv_x", 64'(f_xa), 64'd296);
    repeat (20) cyc();
    check("halt_x", 64'(f_xa), 64'd296);
    check("halt_y", 64'(f_ya), 64'd330);
    f_mv = 1'b1; f_xm = 10'd300; f_ym = 10'd335;
    cyc();
    f_mv = 1'b0; f_tick = 1'b0;
    check("halt_hit", 64'(f_hit), 64'd1);
    check("halt_idx", 64'(f_hidx), 64'd0);
    check("halt_alive", 64'(f_al), 64'hFFFFFFFFE);
    check("halt_inv_sticky", 64'(f_inv), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
